// File: rtl/psum_accum_ctrl.sv
// Sequencer for the partial-sum accumulator lanes: clears, gates in cin_tiles
// partial sums per output tile, waits for settle, then hands the result downstream.
module psum_accum_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_cin_tiles,
    input  logic [CNT_W-1:0] cfg_out_tiles,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             add_en,
    output logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] tile_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SET_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACCUM,
        S_SETTLE,
        S_OUT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cin_cnt_q, cin_cnt_d;
    logic [CNT_W-1:0]   tile_d;
    logic [CNT_W-1:0]   cin_tiles_q, cin_tiles_d;
    logic [CNT_W-1:0]   out_tiles_q, out_tiles_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;

    // in_ready is only ever high in ACCUM, so this is the accepted-input strobe.
    assign add_en = in_valid & in_ready;

    // Next-state and counter logic; counters compare against latched config only.
    always_comb begin
        state_d     = state_q;
        cin_cnt_d   = cin_cnt_q;
        tile_d      = tile_idx;
        cin_tiles_d = cin_tiles_q;
        out_tiles_d = out_tiles_q;
        set_cnt_d   = set_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cin_tiles_d = (cfg_cin_tiles == '0) ? CNT_W'(1) : cfg_cin_tiles;
                    out_tiles_d = (cfg_out_tiles == '0) ? CNT_W'(1) : cfg_out_tiles;
                    tile_d      = '0;
                    state_d     = S_CLR;
                end
            end
            S_CLR: begin
                cin_cnt_d = '0;
                state_d   = S_ACCUM;
            end
            S_ACCUM: begin
                if (add_en) begin
                    if (cin_cnt_q == cin_tiles_q - CNT_W'(1)) begin
                        set_cnt_d = '0;
                        state_d   = S_SETTLE;
                    end else begin
                        cin_cnt_d = cin_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_SETTLE: begin
                if (set_cnt_q == SET_W'(ADD_LAT - 1)) begin
                    state_d = S_OUT;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            S_OUT: begin
                if (out_valid && out_ready) begin
                    if (tile_idx == out_tiles_q - CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        tile_d  = tile_idx + CNT_W'(1);
                        state_d = S_CLR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cin_cnt_q   <= '0;
            tile_idx    <= '0;
            cin_tiles_q <= '0;
            out_tiles_q <= '0;
            set_cnt_q   <= '0;
            in_ready    <= 1'b0;
            acc_clr     <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cin_cnt_q   <= cin_cnt_d;
            tile_idx    <= tile_d;
            cin_tiles_q <= cin_tiles_d;
            out_tiles_q <= out_tiles_d;
            set_cnt_q   <= set_cnt_d;
            in_ready    <= (state_d == S_ACCUM);
            acc_clr     <= (state_d == S_CLR);
            out_valid   <= (state_d == S_OUT);
            busy        <= (state_d != S_IDLE);
            done        <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed bench for psum_accum_ctrl: cycle-exact job timing, stalls, config
// clamping, ignored start/config changes mid-job and reset from busy states.
module tb_psum_accum_ctrl;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] cfg_cin_tiles;
    logic [CNT_W-1:0] cfg_out_tiles;
    logic             in_valid;
    logic             in_ready;
    logic             add_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] tile_idx;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    // Per-job observations gathered by run_job.
    int n_add, n_clr, n_acc, n_done, n_ov, n_overlap;
    int clr_cyc, add_first, add_last, ov_first, acc_cyc, done_cyc, busy_after;
    int adds_t[4];
    int clr_t[4];
    int tile_acc[4];

    psum_accum_ctrl #(.CNT_W(CNT_W), .ADD_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_cin_tiles (cfg_cin_tiles),
        .cfg_out_tiles (cfg_out_tiles),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .add_en        (add_en),
        .acc_clr       (acc_clr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .tile_idx      (tile_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 carries the start pulse; inputs are set, then outputs sampled 1ns later.
    task automatic run_job(input int cin, input int cout, input int vmode,
                           input int stall, input int poke_cyc, input int max_cyc);
        int stall_left;
        int ended;
        n_add = 0; n_clr = 0; n_acc = 0; n_done = 0; n_ov = 0; n_overlap = 0;
        clr_cyc = -1; add_first = -1; add_last = -1; ov_first = -1;
        acc_cyc = -1; done_cyc = -1; busy_after = -1;
        for (int i = 0; i < 4; i++) begin
            adds_t[i] = 0; clr_t[i] = 0; tile_acc[i] = -1;
        end
        stall_left = stall;
        ended = -1;
        for (int c = 0; c < max_cyc; c++) begin
            start = (c == 0) || (c == poke_cyc);
            if (c == 0) begin
                cfg_cin_tiles = CNT_W'(cin);
                cfg_out_tiles = CNT_W'(cout);
            end else if (c == poke_cyc) begin
                cfg_cin_tiles = CNT_W'(7);
                cfg_out_tiles = CNT_W'(3);
            end
            in_valid  = (vmode == 0) ? 1'b1 : ((c % 2) == 0);
            out_ready = (stall_left == 0);
            #1;
            if (add_en) begin
                n_add++;
                if (add_first < 0) add_first = c;
                add_last = c;
                adds_t[tile_idx[1:0]]++;
            end
            if (acc_clr) begin
                n_clr++;
                clr_t[tile_idx[1:0]]++;
                if (clr_cyc < 0) clr_cyc = c;
            end
            if (add_en && acc_clr) n_overlap++;
            if (out_valid && (add_en || acc_clr)) n_overlap++;
            if (out_valid) begin
                n_ov++;
                if (ov_first < 0) ov_first = c;
                if (out_ready) begin
                    tile_acc[n_acc & 3] = int'(tile_idx);
                    n_acc++;
                    acc_cyc = c;
                end else if (stall_left > 0) begin
                    stall_left--;
                end
            end
            if (done) begin
                n_done++;
                done_cyc = c;
                ended = c;
            end
            if (ended >= 0 && c == ended + 1) begin
                busy_after = int'(busy);
                break;
            end
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        cfg_cin_tiles = '0; cfg_out_tiles = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if ({in_ready, add_en, acc_clr, out_valid, busy, done} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000",
                     {in_ready, add_en, acc_clr, out_valid, busy, done});
        end
        total++;
        if (tile_idx !== '0) begin
            bad++;
            $display("FAIL reset_tile got=%0d want=0", tile_idx);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic_timing;
        run_job(3, 1, 0, 0, -1, 40);
        total++;
        if (clr_cyc !== 1) begin bad++; $display("FAIL t1_clr_cycle got=%0d want=1", clr_cyc); end
        total++;
        if (add_first !== 2 || add_last !== 4 || n_add !== 3) begin
            bad++;
            $display("FAIL t1_add_window got=%0d..%0d n=%0d want=2..4 n=3", add_first, add_last, n_add);
        end
        total++;
        if (ov_first !== 6) begin bad++; $display("FAIL t1_out_valid_cycle got=%0d want=6", ov_first); end
        total++;
        if (done_cyc !== 7 || n_done !== 1) begin
            bad++;
            $display("FAIL t1_done got=%0d n=%0d want=7 n=1", done_cyc, n_done);
        end
        total++;
        if (busy_after !== 0) begin bad++; $display("FAIL t1_busy_after got=%0d want=0", busy_after); end
    endtask

    task automatic test_gapped_input;
        run_job(4, 2, 1, 0, -1, 80);
        total++;
        if (adds_t[0] !== 4 || adds_t[1] !== 4) begin
            bad++;
            $display("FAIL t2_adds_per_tile got=%0d,%0d want=4,4", adds_t[0], adds_t[1]);
        end
        total++;
        if (clr_t[0] !== 1 || clr_t[1] !== 1) begin
            bad++;
            $display("FAIL t2_clr_per_tile got=%0d,%0d want=1,1", clr_t[0], clr_t[1]);
        end
        total++;
        if (n_acc !== 2 || tile_acc[0] !== 0 || tile_acc[1] !== 1) begin
            bad++;
            $display("FAIL t2_tile_order got n=%0d %0d,%0d want n=2 0,1", n_acc, tile_acc[0], tile_acc[1]);
        end
        total++;
        if (done_cyc !== 21 || n_done !== 1) begin
            bad++;
            $display("FAIL t2_done got=%0d n=%0d want=21 n=1", done_cyc, n_done);
        end
    endtask

    task automatic test_out_stall;
        run_job(2, 1, 0, 5, -1, 60);
        total++;
        if (ov_first !== 5 || n_ov !== 6) begin
            bad++;
            $display("FAIL t3_out_valid_hold got first=%0d n=%0d want first=5 n=6", ov_first, n_ov);
        end
        total++;
        if (acc_cyc !== 10 || done_cyc !== 11) begin
            bad++;
            $display("FAIL t3_accept_done got=%0d,%0d want=10,11", acc_cyc, done_cyc);
        end
        total++;
        if (n_overlap !== 0 || n_add !== 2 || n_clr !== 1) begin
            bad++;
            $display("FAIL t3_quiet_during_stall got ovl=%0d add=%0d clr=%0d want 0,2,1", n_overlap, n_add, n_clr);
        end
    endtask

    task automatic test_zero_cfg;
        run_job(0, 0, 0, 0, -1, 40);
        total++;
        if (n_add !== 1 || n_ov !== 1 || n_acc !== 1) begin
            bad++;
            $display("FAIL t4_zero_as_one got add=%0d ov=%0d acc=%0d want 1,1,1", n_add, n_ov, n_acc);
        end
        total++;
        if (done_cyc !== 5 || n_done !== 1) begin
            bad++;
            $display("FAIL t4_done got=%0d n=%0d want=5 n=1", done_cyc, n_done);
        end
    endtask

    task automatic test_start_ignored;
        run_job(3, 2, 0, 0, 3, 80);
        total++;
        if (adds_t[0] !== 3 || adds_t[1] !== 3 || n_add !== 6) begin
            bad++;
            $display("FAIL t5_latched_cin got=%0d,%0d n=%0d want=3,3 n=6", adds_t[0], adds_t[1], n_add);
        end
        total++;
        if (n_acc !== 2 || done_cyc !== 13 || n_done !== 1) begin
            bad++;
            $display("FAIL t5_latched_out got acc=%0d done=%0d n=%0d want 2,13,1", n_acc, done_cyc, n_done);
        end
    endtask

    task automatic test_reset_midjob;
        int seen;
        // Reset while presenting tile 1 in OUT.
        cfg_cin_tiles = CNT_W'(1); cfg_out_tiles = CNT_W'(3);
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            out_ready = (tile_idx == '0);
            #1;
            if (out_valid && tile_idx == CNT_W'(1)) seen = 1;
            else tick();
        end
        total++;
        if (seen !== 1) begin bad++; $display("FAIL t6_reach_out got=%0d want=1", seen); end
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0; in_valid = 1'b1;
        #1;
        total++;
        if ({in_ready, add_en, acc_clr, out_valid, busy, done} !== 6'b0 || tile_idx !== '0) begin
            bad++;
            $display("FAIL t6_reset_in_out got=%b tile=%0d want=000000 tile=0",
                     {in_ready, add_en, acc_clr, out_valid, busy, done}, tile_idx);
        end
        tick();
        // Reset while ACCUM waits on a gap in in_valid.
        cfg_cin_tiles = CNT_W'(5); cfg_out_tiles = CNT_W'(1);
        in_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL t6_in_accum got=%b want=1", in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b1;
        #1;
        total++;
        if ({in_ready, add_en, acc_clr, out_valid, busy, done} !== 6'b0 || tile_idx !== '0) begin
            bad++;
            $display("FAIL t6_reset_in_accum got=%b tile=%0d want=000000 tile=0",
                     {in_ready, add_en, acc_clr, out_valid, busy, done}, tile_idx);
        end
        tick();
        run_job(3, 1, 0, 0, -1, 40);
        total++;
        if (n_add !== 3 || tile_acc[0] !== 0 || done_cyc !== 7) begin
            bad++;
            $display("FAIL t6_fresh_job got add=%0d tile=%0d done=%0d want 3,0,7", n_add, tile_acc[0], done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        tick();
        test_gapped_input();
        tick();
        test_out_stall();
        tick();
        test_zero_cfg();
        tick();
        test_start_ignored();
        tick();
        test_reset_midjob();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
